// File: rtl/dig_ota_sar_ctrl.sv
// Successive-approximation controller: samples, then resolves WIDTH bits MSB-first from a 2-flop synced comparator.
// Latency SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1 cycles from start; no backpressure, abort cancels any trial.
module dig_ota_sar_ctrl #(
  parameter int WIDTH         = 6,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    TOP_BIT   = IW'(WIDTH - 1);
  localparam logic [3:0]       SAMP_LAST = 4'(SAMPLE_CYCLES - 1);
  localparam logic [3:0]       SETL_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] TOP_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_SETTLE, S_DECIDE, S_DONE} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [IW-1:0]    bit_q;
  logic             sync1_q, sync2_q;
  logic             sample_q, busy_q, done_q;
  logic [WIDTH-1:0] dac_q, result_q;
  logic [WIDTH-1:0] kept_d, next_trial_d;

  // The current trial code with bit i replaced by the synchronized decision.
  always_comb begin
    kept_d       = dac_q;
    kept_d[bit_q] = sync2_q;
    next_trial_d = '0;
    if (bit_q != '0) next_trial_d[bit_q - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dac_q    <= '0;
      result_q <= '0;
    end else begin
      sync1_q <= cmp_i;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;
      if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        sample_q <= 1'b0;
        busy_q   <= 1'b0;
        dac_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              state_q  <= S_SAMPLE;
              cnt_q    <= '0;
              sample_q <= 1'b1;
              busy_q   <= 1'b1;
              dac_q    <= '0;
            end
          end
          S_SAMPLE: begin
            if (cnt_q == SAMP_LAST) begin
              state_q  <= S_SETTLE;
              cnt_q    <= '0;
              sample_q <= 1'b0;
              bit_q    <= TOP_BIT;
              dac_q    <= TOP_TRIAL;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_SETTLE: begin
            if (cnt_q == SETL_LAST) begin
              state_q <= S_DECIDE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_DECIDE: begin
            if (bit_q == '0) begin
              state_q  <= S_DONE;
              dac_q    <= kept_d;
              result_q <= kept_d;
              done_q   <= 1'b1;
            end else begin
              state_q <= S_SETTLE;
              bit_q   <= bit_q - IW'(1);
              dac_q   <= kept_d | next_trial_d;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dac_q   <= '0;
          end
          default: begin
            state_q  <= S_IDLE;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            dac_q    <= '0;
          end
        endcase
      end
    end
  end

  assign sample_o   = sample_q;
  assign dac_code_o = dac_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_dig_ota_sar_ctrl.sv
// Bench for dig_ota_sar_ctrl: ideal comparator models, scoreboard of expected results and done cycles.
module tb_dig_ota_sar_ctrl;

  localparam int SA = 2, ST = 2, WA = 6;
  localparam int LA = SA + WA * (ST + 1) + 1;
  localparam int LB = 3 + 8 * 5 + 1;

  typedef struct {int res; int cyc;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_a = 0;

  logic       start_a = 1'b0, abort_a = 1'b0, cmp_a;
  logic       sample_a, busy_a, done_a;
  logic [5:0] dac_a, result_a, xa = '0;
  logic       start_b = 1'b0, abort_b = 1'b0, cmp_b;
  logic       sample_b, busy_b, done_b;
  logic [7:0] dac_b, result_b, xb = '0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  assign cmp_a = (xa >= dac_a);
  assign cmp_b = (xb >= dac_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dig_ota_sar_ctrl #(.WIDTH(6), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a), .cmp_i(cmp_a),
    .sample_o(sample_a), .dac_code_o(dac_a), .busy_o(busy_a), .done_o(done_a), .result_o(result_a));

  dig_ota_sar_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(3), .SETTLE_CYCLES(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b), .cmp_i(cmp_b),
    .sample_o(sample_b), .dac_code_o(dac_b), .busy_o(busy_b), .done_o(done_b), .result_o(result_b));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Binary search view of the trial code: resolved upper bits of x plus the bit under test.
  function automatic int exp_dac(input int x, input int c);
    int j;
    if (c <= SA || c > LA) return 0;
    if (c == LA) return x;
    j = WA - 1 - (c - SA - 1) / (ST + 1);
    return ((x >> (j + 1)) << (j + 1)) | (1 << j);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("result_a", int'(result_a), ea.res);
        chk("dac_in_done_a", int'(dac_a), ea.res);
        chk("done_cycle_a", cyc, ea.cyc);
        last_a = ea.res;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("result_b", int'(result_b), eb.res);
        chk("done_cycle_b", cyc, eb.cyc);
      end
    end
  end

  task automatic conv_a(input int x, input int abort_at, input int rst_at, input bit pulses);
    int k;
    bit cut;
    cut = 1'b0;
    @(posedge clk); #1;
    xa = 6'(x);
    start_a = 1'b1;
    k = cyc;
    if (abort_at < 0 && rst_at < 0) qa.push_back('{x, k + LA});
    for (int c = 1; c <= LA + 1 && !cut; c++) begin
      @(posedge clk); #1;
      start_a = pulses && (c == 5 || c == 21);
      abort_a = (c == abort_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_sample", int'(sample_a), 0);
        chk("rst_dac", int'(dac_a), 0);
        chk("rst_result", int'(result_a), 0);
        cut = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        last_a = 0;
      end else begin
        @(negedge clk);
        if (abort_at >= 0 && c == abort_at + 1) begin
          chk("abort_busy", int'(busy_a), 0);
          chk("abort_dac", int'(dac_a), 0);
          chk("abort_sample", int'(sample_a), 0);
          chk("abort_result_held", int'(result_a), last_a);
          cut = 1'b1;
        end else begin
          chk("busy_a", int'(busy_a), (c <= LA) ? 1 : 0);
          chk("sample_a", int'(sample_a), (c <= SA) ? 1 : 0);
          chk("dac_a", int'(dac_a), exp_dac(x, c));
        end
      end
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  task automatic conv_b(input int x);
    int k;
    @(posedge clk); #1;
    xb = 8'(x);
    start_b = 1'b1;
    k = cyc;
    qb.push_back('{x, k + LB});
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (LB) @(posedge clk);
    @(negedge clk);
    chk("busy_b_after", int'(busy_b), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_sample", int'(sample_a), 0);
    chk("reset_dac", int'(dac_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_result", int'(result_a), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // Simultaneous start and abort in IDLE must not launch a conversion.
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", int'(busy_a), 0);
    start_a = 1'b0;
    abort_a = 1'b0;

    conv_a(45, -1, -1, 1'b0);
    conv_a(0, -1, -1, 1'b0);
    conv_a(63, -1, -1, 1'b0);
    conv_a(45, 10, -1, 1'b0);
    conv_a(45, -1, -1, 1'b0);
    conv_a(30, -1, -1, 1'b1);
    conv_a(20, -1, 12, 1'b0);
    conv_a(17, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      conv_a(int'($urandom_range(0, 63)), -1, -1, 1'b0);
    end

    conv_b(200);
    conv_b(0);
    conv_b(255);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      conv_b(int'($urandom_range(0, 255)));
    end

    repeat (5) @(negedge clk);
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dig_ota_sar_ctrl.md
# dig_ota_sar_ctrl

Successive-approximation controller that turns the digital OTA comparator into a WIDTH-bit ADC. It drives a binary-weighted DAC code onto the comparator's reference input and reads the comparator decision back through a 2-flop synchronizer. It resolves one bit per trial, MSB first, and reports the result with a one-cycle done pulse. It sits between the top-level pin wrapper (start/abort from `ui_in`, result to `uo_out`) and the comparator/DAC pair.

## Interface

- WIDTH, 6, conversion resolution in bits; legal range 2..8
- SAMPLE_CYCLES, 2, cycles the `sample` output is held high; legal range 1..15
- SETTLE_CYCLES, 2, cycles the DAC code is held before each decision; legal range 2..15 (≥2 covers the synchronizer)

Ports:

- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a conversion; sampled only in IDLE
- abort  in  1  synchronous cancel; takes priority over start
- cmp  in  1  comparator output; 1 = input ≥ DAC level; asynchronous to clk
- sample  out  1  track/sample switch enable, high only in SAMPLE
- dac_code  out  WIDTH  code driven to the reference DAC
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when result updates
- result  out  WIDTH  last completed conversion; held until the next done

## Operation

- All outputs are registered.
- Reset values: state IDLE, sample=0, dac_code=0, busy=0, done=0, result=0, synchronizer flops=0, counters=0.
- cmp passes through two flops (cmp_sync). Decisions use only cmp_sync.
- States:
  - IDLE: dac_code=0. If start=1 and abort=0, go to SAMPLE.
  - SAMPLE: sample=1, dac_code=0 for SAMPLE_CYCLES cycles. On exit, bit index i=WIDTH-1 and trial = 1<<i.
  - SETTLE: dac_code = kept bits | (1<<i), held for SETTLE_CYCLES cycles, then go to DECIDE.
  - DECIDE: dac_code unchanged. If cmp_sync=1, keep bit i; otherwise clear it.
    - If i=0, go to DONE.
    - Otherwise decrement i and go to SETTLE.
  - DONE: result = final code, dac_code = final code, done=1. Next state is IDLE.
- abort=1 in any non-IDLE state except DONE: next state IDLE, dac_code=0, sample=0, no done, result unchanged.
- abort in DONE is ignored; the conversion completes.
- start is ignored in every state other than IDLE. It is level-sensitive: start held high re-triggers in the first IDLE cycle.
- Kept bits are cleared on entry to SAMPLE. No partial code carries between conversions.

## Timing

- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- SAMPLE occupies cycles 1..SAMPLE_CYCLES.
- Each bit takes SETTLE_CYCLES + 1 cycles.
- DONE cycle: L = SAMPLE_CYCLES + WIDTH·(SETTLE_CYCLES+1) + 1. With default parameters L = 21.
- busy is high in cycles 1..L. The earliest next start is accepted in cycle L+1.
- Decision latency: cmp must be stable from the first SETTLE cycle of a bit. The DECIDE value reflects cmp as sampled two edges earlier.
- Async reset mid-conversion: all outputs go to their reset values immediately, independent of clk. No done pulse. After rst_n releases, the block is in IDLE.
- Simultaneous start+abort in IDLE: stays in IDLE.

## Test plan

- Defaults, ideal comparator model cmp = (X ≥ dac_code) with X=45: the dac_code trial sequence is 32, 48→32, 40, 44, 46→44, 45. Required: result=45, done pulses in cycle 21, busy high for cycles 1..21.
- Endpoints: X=0 → result=0, dac_code 0 in DONE. X=63 → result=63. Both complete in 21 cycles.
- Abort asserted in cycle 10 of a conversion with X=45: state is IDLE in cycle 11, no done, result keeps its prior value, dac_code=0. The next start yields result=45.
- start pulsed again in cycles 5 and 21 of a running conversion: both are ignored. Exactly one done pulse occurs; the next conversion begins only for a start sampled in cycle ≥22.
- rst_n pulled low in cycle 12: all outputs read 0 within the same cycle, with no done. After release, a fresh conversion with X=17 gives result=17.
- WIDTH=8, SAMPLE_CYCLES=3, SETTLE_CYCLES=4, X=200: result=200, done in cycle 3+8·5+1=44.
